// File: rtl/io_uart_tx_responder.sv
// io_uart_tx_responder
//   Memory-mapped 8N1 UART transmitter sitting on the MEM-stage IO window.
//   Word stores push bytes into a TX FIFO; a baud FSM shifts them out on o_tx.
//   Loads are answered combinationally in the access cycle.
//
// Ports
//   i_clk        core clock
//   i_rst        synchronous active-high reset
//   i_clk_en     global clock enable, all state holds while low
//   i_io_en      IO window selected
//   i_mem_write  store strobe
//   i_addr       byte offset in window (0x0 TXDATA, 0x4 STATUS, 0x8 DIVISOR, 0xC CTRL)
//   i_wr_data    store data
//   o_rd_data    load data (combinational)
//   o_tx         serial line, idle high
//   o_tx_busy    frame in progress
//   o_irq        level interrupt: irq_en & FIFO empty & not busy (registered)
//
// TX FSM states
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | line high, waiting for tx_en and a queued byte
//   ST_START | start bit (low) for one bit time
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (high); may chain straight into ST_START
module io_uart_tx_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_io_en,
  input  logic        i_mem_write,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_tx,
  output logic        o_tx_busy,
  output logic        o_irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // state
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic          tx_en_q, tx_en_d;
  logic          irq_en_q, irq_en_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          irq_q, irq_d;

  // bus decode
  logic       access;
  logic       wr_en;
  logic [1:0] reg_sel;
  logic       push_req;
  logic       flush;
  logic       ovf_clr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       busy;
  logic       pop;
  logic       load_frame;
  logic       push_ok;
  logic [31:0] status_word;
  logic       unused_wr_bits;

  assign access     = i_io_en && (i_addr[1:0] == 2'b00);
  assign reg_sel    = i_addr[3:2];
  assign wr_en      = access && i_mem_write && i_clk_en;
  assign push_req   = wr_en && (reg_sel == REG_TXDATA);
  assign flush      = wr_en && (reg_sel == REG_CTRL) && i_wr_data[2];
  assign ovf_clr    = wr_en && (reg_sel == REG_STATUS) && i_wr_data[3];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign busy       = (state_q != ST_IDLE);

  assign unused_wr_bits = &{1'b0, i_wr_data[31:16]};

  // TX FSM; every transition is gated by a clock-enable tick
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    div_lat_d  = div_lat_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    load_frame = 1'b0;
    if (i_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (tx_en_q && !fifo_empty) load_frame = 1'b1;
        end
        ST_START: begin
          if (baud_q == 16'd0) begin
            state_d   = ST_DATA;
            baud_d    = div_lat_q - 16'd1;
            bit_idx_d = 3'd0;
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_q == 16'd0) begin
            baud_d = div_lat_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        default: begin // ST_STOP
          if (baud_q == 16'd0) begin
            if (tx_en_q && !fifo_empty) load_frame = 1'b1;
            else                        state_d    = ST_IDLE;
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
      endcase
    end
    // Divisor is captured per frame so mid-frame DIVISOR writes wait for the next one.
    if (load_frame) begin
      state_d   = ST_START;
      shift_d   = fifo_mem_q[rd_ptr_q];
      div_lat_d = div_q;
      baud_d    = div_q - 16'd1;
    end
  end

  assign pop = load_frame;

  // FIFO bookkeeping; a pop frees the slot a same-cycle push lands in
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    push_ok  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      push_ok = push_req && (!fifo_full || pop);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop)      count_d = count_q + CNT_ONE;
      else if (!push_ok && pop) count_d = count_q - CNT_ONE;
      if (push_req && !push_ok) ovf_d = 1'b1;
    end
    if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    div_d    = div_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (wr_en && (reg_sel == REG_DIVISOR)) begin
      div_d = (i_wr_data[15:0] == 16'd0) ? 16'd1 : i_wr_data[15:0];
    end
    if (wr_en && (reg_sel == REG_CTRL)) begin
      tx_en_d  = i_wr_data[0];
      irq_en_d = i_wr_data[1];
    end
  end

  assign irq_d = i_clk_en ? (irq_en_q && fifo_empty && !busy) : irq_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= 16'(DEFAULT_DIV);
      tx_en_q   <= 1'b1;
      irq_en_q  <= 1'b0;
      state_q   <= ST_IDLE;
      baud_q    <= 16'd0;
      div_lat_q <= 16'(DEFAULT_DIV);
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      tx_en_q   <= tx_en_d;
      irq_en_q  <= irq_en_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push_ok) fifo_mem_q[wr_ptr_q] <= i_wr_data[7:0];
  end

  always_comb begin
    status_word         = '0;
    status_word[0]      = fifo_full;
    status_word[1]      = fifo_empty;
    status_word[2]      = busy;
    status_word[3]      = ovf_q;
    status_word[8 +: CW] = count_q;
  end

  always_comb begin
    o_rd_data = '0;
    if (access) begin
      case (reg_sel)
        REG_STATUS:  o_rd_data = status_word;
        REG_DIVISOR: o_rd_data = {16'd0, div_q};
        REG_CTRL:    o_rd_data = {30'd0, irq_en_q, tx_en_q};
        default:     o_rd_data = '0;
      endcase
    end
  end

  assign o_tx      = (state_q == ST_START) ? 1'b0 :
                     (state_q == ST_DATA)  ? shift_q[0] : 1'b1;
  assign o_tx_busy = busy;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_io_uart_tx_responder.sv
// Self-checking bench for io_uart_tx_responder: directed scenarios plus
// randomized byte bursts under a random clock enable. A line monitor decodes
// frames by counting clock-enable ticks and compares them with a queue of
// bytes the bench expects to be transmitted.
module tb_io_uart_tx_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clk_en = 1'b1;
  logic        i_io_en = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [3:0]  i_addr = 4'h0;
  logic [31:0] i_wr_data = 32'h0;
  logic [31:0] o_rd_data;
  logic        o_tx, o_tx_busy, o_irq;

  io_uart_tx_responder #(.FIFO_DEPTH(8), .DEFAULT_DIV(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_io_en(i_io_en),
    .i_mem_write(i_mem_write), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .o_rd_data(o_rd_data), .o_tx(o_tx), .o_tx_busy(o_tx_busy), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // STATUS word from the register map rules, depth 8
  function automatic logic [31:0] status_of(input int cnt, input bit bsy, input bit ovf);
    logic [31:0] s;
    s = 32'(cnt) << 8;
    if (cnt == 8) s[0] = 1'b1;
    if (cnt == 0) s[1] = 1'b1;
    s[2] = bsy;
    s[3] = ovf;
    return s;
  endfunction

  // clock-enable driver
  bit rand_ce  = 1'b0;
  bit ce_force = 1'b1;
  always @(posedge i_clk) begin
    #1;
    i_clk_en = rand_ce ? ($urandom_range(0, 3) != 0) : ce_force;
  end

  // line monitor
  logic [7:0] exp_q[$];
  int         mon_div = 16;
  bit         mon_en  = 1'b1;
  bit         m_act   = 1'b0;
  int         m_tick, m_d, m_last;
  bit         m_bad;
  logic [7:0] m_byte;

  always @(negedge i_clk) begin
    int slot;
    logic [7:0] e;
    if (!mon_en) m_act = 1'b0;
    else if (!m_act && o_tx === 1'b0) begin
      m_act = 1'b1; m_tick = 0; m_d = mon_div; m_last = -1; m_bad = 1'b0; m_byte = 8'h00;
    end
    if (m_act) begin
      slot = m_tick / m_d;
      if (o_tx_busy !== 1'b1) m_bad = 1'b1;
      if (slot == 0) begin
        if (o_tx !== 1'b0) m_bad = 1'b1;
      end else if (slot == 9) begin
        if (o_tx !== 1'b1) m_bad = 1'b1;
      end else begin
        if (slot != m_last) m_byte[slot-1] = o_tx;
        else if (m_byte[slot-1] !== o_tx) m_bad = 1'b1;
      end
      m_last = slot;
      if (i_clk_en) m_tick++;
      if (m_tick == 10 * m_d) begin
        m_act = 1'b0;
        if (exp_q.size() == 0) chk_eq("frame_unexpected", 32'(m_byte) | 32'h100, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk_eq("frame_byte", 32'(m_byte), 32'(e));
        end
        chk_eq("frame_shape", 32'(m_bad), 32'h0);
      end
    end
  end

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    i_io_en = 1'b1; i_mem_write = 1'b0; i_addr = a;
    #1;
    d = o_rd_data;
    i_io_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_io_en = 1'b1; i_mem_write = 1'b1; i_addr = a; i_wr_data = d;
    for (int k = 0; k < 64; k++) begin
      @(posedge i_clk);
      if (i_clk_en) break;
    end
    #1;
    i_io_en = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic drain(input int budget);
    logic [31:0] st;
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge i_clk);
      if (!o_tx_busy && !m_act) begin
        rd(4'h4, st);
        if (st[1]) break;
      end
    end
    chk_eq("drain_timeout", 32'(k >= budget), 32'h0);
    @(posedge i_clk); #1;
  endtask

  task automatic count_busy(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge i_clk);
      if (o_tx_busy) n++;
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          nb, hi, n, dv;
    logic [7:0]  b;

    step(2);
    i_rst = 1'b0;
    step(1);

    // reset state
    rd(4'h4, d); chk_eq("rst_status", d, status_of(0, 0, 0));
    rd(4'h8, d); chk_eq("rst_div", d, 32'd16);
    rd(4'hC, d); chk_eq("rst_ctrl", d, 32'h1);
    chk_eq("rst_tx", 32'(o_tx), 32'h1);
    chk_eq("rst_irq", 32'(o_irq), 32'h0);
    chk_eq("rst_busy", 32'(o_tx_busy), 32'h0);

    // misaligned accesses have no effect and read 0
    wr(4'h9, 32'h5);
    wr(4'h1, 32'hAA);
    wr(4'hE, 32'h0);
    rd(4'h8, d); chk_eq("misalign_div", d, 32'd16);
    rd(4'h9, d); chk_eq("misalign_rd", d, 32'h0);
    rd(4'h4, d); chk_eq("misalign_status", d, status_of(0, 0, 0));
    rd(4'hC, d); chk_eq("misalign_ctrl", d, 32'h1);

    // divisor of 0 is stored as 1
    wr(4'h8, 32'h0);
    rd(4'h8, d); chk_eq("div_zero", d, 32'd1);

    // single frame, divisor 4
    wr(4'h8, 32'd4); mon_div = 4;
    rd(4'h8, d); chk_eq("div4", d, 32'd4);
    wr(4'h0, 32'h55); exp_q.push_back(8'h55);
    count_busy(60, nb);
    chk_eq("busy_len_div4", 32'(nb), 32'd40);
    rd(4'h4, d); chk_eq("status_after_frame", d, status_of(0, 0, 0));
    chk_eq("q_after_frame", 32'(exp_q.size()), 32'd0);

    // overflow with transmitter disabled
    wr(4'h8, 32'd2); mon_div = 2;
    wr(4'hC, 32'h0);
    for (int i = 0; i < 9; i++) begin
      wr(4'h0, 32'(i));
      if (i < 8) exp_q.push_back(8'(i));
    end
    rd(4'h4, d); chk_eq("status_overflow", d, status_of(8, 0, 1));
    wr(4'h4, 32'h8);
    rd(4'h4, d); chk_eq("status_ovf_clr", d, status_of(8, 0, 0));

    // enable, then push on the very edge of the first pop while full
    wr(4'hC, 32'h1);
    wr(4'h0, 32'h99); exp_q.push_back(8'h99);
    rd(4'h4, d); chk_eq("push_pop_full", d, status_of(8, 1, 0));
    count_busy(300, nb);
    chk_eq("b2b_busy_len", 32'(nb), 32'd180);
    drain(200);
    chk_eq("q_after_b2b", 32'(exp_q.size()), 32'd0);

    // flush mid-frame: current byte completes, queued bytes dropped
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      wr(4'h0, 32'(b));
      if (i == 0) exp_q.push_back(b);
    end
    wr(4'hC, 32'h5);
    rd(4'h4, d); chk_eq("status_flush", d, status_of(0, 1, 0));
    rd(4'hC, d); chk_eq("ctrl_flush_rd", d, 32'h1);
    drain(200);
    chk_eq("q_after_flush", 32'(exp_q.size()), 32'd0);

    // reset in the middle of data bit 3
    wr(4'h0, 32'hC3); exp_q.push_back(8'hC3);
    step(9);
    chk_eq("pre_rst_busy", 32'(o_tx_busy), 32'h1);
    mon_en = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk_eq("midrst_tx", 32'(o_tx), 32'h1);
    chk_eq("midrst_busy", 32'(o_tx_busy), 32'h0);
    chk_eq("midrst_irq", 32'(o_irq), 32'h0);
    rd(4'h4, d); chk_eq("midrst_status", d, status_of(0, 0, 0));
    rd(4'h8, d); chk_eq("midrst_div", d, 32'd16);
    rd(4'hC, d); chk_eq("midrst_ctrl", d, 32'h1);
    exp_q.delete();
    mon_div = 16;
    mon_en = 1'b1;

    // interrupt timing, divisor 1
    wr(4'h8, 32'd1); mon_div = 1;
    wr(4'hC, 32'h3);
    step(2);
    chk_eq("irq_idle", 32'(o_irq), 32'h1);
    wr(4'h0, 32'hA5); exp_q.push_back(8'hA5);
    @(posedge i_clk);
    hi = 0; n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (!o_tx_busy) break;
      n++;
      if (o_irq) hi = 1;
    end
    chk_eq("irq_frame_len", 32'(n), 32'd10);
    chk_eq("irq_during_frame", 32'(hi), 32'h0);
    chk_eq("irq_stop_end", 32'(o_irq), 32'h0);
    @(negedge i_clk);
    chk_eq("irq_after_stop", 32'(o_irq), 32'h1);
    @(posedge i_clk); #1;
    wr(4'h0, 32'h5A); exp_q.push_back(8'h5A);
    step(1);
    chk_eq("irq_after_push", 32'(o_irq), 32'h0);
    drain(100);

    // clock enable held low for 5 cycles mid-bit stretches the frame by 5
    wr(4'hC, 32'h1);
    wr(4'h8, 32'd4); mon_div = 4;
    wr(4'h0, 32'h0F); exp_q.push_back(8'h0F);
    nb = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge i_clk);
      if (o_tx_busy) nb++;
      if (k == 10) ce_force = 1'b0;
      if (k == 15) ce_force = 1'b1;
    end
    @(posedge i_clk); #1;
    chk_eq("ce_stretch_len", 32'(nb), 32'd45);
    drain(100);

    // randomized bursts with a random clock enable
    for (int r = 0; r < 6; r++) begin
      dv = $urandom_range(1, 3);
      wr(4'h8, 32'(dv)); mon_div = dv;
      rd(4'h8, d); chk_eq("rnd_div", d, 32'(dv));
      rand_ce = 1'b1;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        wr(4'h0, {24'($urandom), b});
        exp_q.push_back(b);
        step($urandom_range(0, 2));
      end
      drain(2000);
      rand_ce = 1'b0;
      step(1);
      chk_eq("rnd_q_empty", 32'(exp_q.size()), 32'd0);
      rd(4'h4, d); chk_eq("rnd_status", d, status_of(0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
